gen_count_display: RTL and testbench
====================================

// Module: gen_count_display
// PURPOSE
//  - Counts Game-of-Life generations and drives six 7-segment digits with the decimal count.
//  - Sits between the life-grid engine, which emits a generation tick, and the board HEX pins.
//  - Outputs are ACTIVE-HIGH segment patterns. The top level applies the per-bit inversion
//    that the active-low DE1-SoC HEX pins require.
// PARAMETERS
//  - DIGITS  default 6  number of BCD digits/displays; legal range 1..6
//  - WRAP    default 1  1: roll over from max to 0; 0: saturate at max (all 9s)
// PORTS
//  clk       in   1  system clock (50 MHz)
//  reset_n   in   1  synchronous, active-low reset
//  gen_tick  in   1  level from engine; each rising edge = one generation
//  hold      in   1  1: ignore gen_tick edges (count frozen); edges during hold are lost
//  clear     in   1  synchronous clear of count and ovf
//  hex0      out  7  digit 0 (least significant), bit0=seg a .. bit6=seg g, active-high
//  hex1..5   out  7  digits 1..5; digits >= DIGITS are driven 7'h00
//  ovf       out  1  sticky: set when the count reaches max+1 (wrap or saturate event)
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): count=0, tick_q=0, ovf=0; hex regs take reset pattern
//    (see CONFIGURATION). Reset mid-count discards state at that edge; no partial update.
//  - Edge detect: tick_q <= gen_tick every cycle, including during hold;
//    inc = gen_tick & ~tick_q & ~hold & ~clear.
//    A gen_tick held high yields exactly one inc.
//  - Priority: reset_n > clear > inc. If clear and an edge coincide -> count=0, edge dropped.
//  - BCD increment, single cycle:
//    - digit[0] increments on inc;
//    - digit[i] increments when inc and all digit[j<i]==9;
//    - any incremented digit at 9 becomes 0.
//    - Never produces A-F; each digit is 4 bits, values 0..9.
//  - Max (all DIGITS == 9) plus inc:
//    - WRAP=1 -> count=0, ovf<=1;
//    - WRAP=0 -> count unchanged, ovf<=1.
//  - ovf cleared only by reset or clear.
//  - Latency: edge on gen_tick seen at posedge N -> count updated at N -> hex* valid at N+1
//    (registered decode). ovf updates at N.
//  - Decode 0..9:
//    3F 06 5B 4F 66 6D 7D 07 7F 6F
// CONFIGURATION
//  - Macro GEN_LZ_BLANK_EN.
//  - Defined: leading-zero blanking.
//    - Digit i>0 outputs 7'h00 when it and all higher digits are 0.
//    - Digit 0 always displays.
//    - Reset pattern: hex0=7'h3F, others 7'h00.
//  - Undefined: all DIGITS digits always displayed.
//    - Reset pattern: hex0..hex(DIGITS-1)=7'h3F.
// STRUCTURE
//  - seg7_pkg (shared): SEG_BLANK=7'h00, seg7_t typedef (logic [6:0]), bcd_t typedef
//    (logic [3:0]), SEG_DIGIT[10] constant table, function bcd_to_seg(bcd_t) returning seg7_t.
//    bcd_to_seg returns SEG_BLANK for inputs above 9.
//  - Sub-module bcd_digit:
//    - ports clk, reset_n, clr, inc_in, q[3:0], carry_out;
//    - carry_out = inc_in & (q==9);
//    - instantiated DIGITS times in a generate chain.
//  - Top holds edge detect, saturate/wrap control, ovf, blanking mask and the output registers.
// TESTING
//  1. Reset: hold reset_n=0 2 cycles -> count 0, ovf=0; hex0=3F.
//     With GEN_LZ_BLANK_EN, hex1..5=00; without it, all six =3F.
//  2. Count: 12 gen_tick pulses, each 1 high / 3 low -> hex1=06, hex0=5B one cycle after the
//     12th edge. Also: gen_tick held high 20 cycles -> count +1 only.
//  3. Ripple: preload 009999 via 9999 pulses, one more -> 010000.
//     hex4=06, hex3..0=3F; hex5=00 (blank) or 3F.
//  4. Wrap/saturate: from 999999, one edge.
//     WRAP=1 -> 000000, ovf=1.
//     WRAP=0 -> stays 999999, ovf=1; a further edge leaves both unchanged.
//  5. Priority: clear and edge in same cycle -> count 0, ovf 0.
//     hold=1 with 5 edges -> count unchanged. Release hold with gen_tick high -> no increment.
//  6. Mid-op reset: reset_n=0 for 1 cycle at count 000123 with a coincident edge -> 000000,
//     next edge -> 000001.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display blocks.
// Provides the segment and BCD digit types, the blank pattern, the 0..9 segment
// table (bit0 = seg a .. bit6 = seg g, active-high) and the BCD-to-segment decoder.
package seg7_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;

  localparam seg7_t SEG_BLANK = 7'h00;

  localparam seg7_t SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Number of physical displays on the board; DIGITS may use fewer of them.
  localparam int MAX_DIGITS = 6;

  // Values above 9 cannot occur in a well-formed count; they decode to blank.
  function automatic seg7_t bcd_to_seg(input bcd_t v);
    seg7_t s;
    case (v)
      4'd0:    s = SEG_DIGIT[0];
      4'd1:    s = SEG_DIGIT[1];
      4'd2:    s = SEG_DIGIT[2];
      4'd3:    s = SEG_DIGIT[3];
      4'd4:    s = SEG_DIGIT[4];
      4'd5:    s = SEG_DIGIT[5];
      4'd6:    s = SEG_DIGIT[6];
      4'd7:    s = SEG_DIGIT[7];
      4'd8:    s = SEG_DIGIT[8];
      4'd9:    s = SEG_DIGIT[9];
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the generation counter.
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset (digit -> 0)
//   clr       in   synchronous clear (digit -> 0), below reset in priority
//   inc_in    in   increment request from the lower digit (or the edge detector)
//   q         out  current digit value 0..9
//   carry_out out  increment request for the next higher digit
module bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc_in,
  output bcd_t q,
  output logic carry_out
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (inc_in)
      q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q         = q_q;
  assign carry_out = inc_in & (q_q == 4'd9);

endmodule

// File: rtl/gen_count_display.sv
// Game-of-Life generation counter driving six active-high 7-segment digits.
// Rising edges of gen_tick advance a DIGITS-wide BCD count; the count is decoded
// into registered segment patterns one cycle later.
// Parameters: DIGITS (1..6) displays in use, WRAP (1 roll over, 0 saturate at all 9s).
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   gen_tick       generation level from the engine, counted on rising edges
//   hold           freezes the count; edges seen while high are lost
//   clear          synchronous clear of count and ovf
//   hex0..hex5     segment patterns, hex0 least significant, unused digits 7'h00
//   ovf            sticky overflow, set when the count passes its maximum
// Optional feature: define GEN_LZ_BLANK_EN for leading-zero blanking.
module gen_count_display
  import seg7_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int WRAP   = 1
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  gen_tick,
  input  logic  hold,
  input  logic  clear,
  output seg7_t hex0,
  output seg7_t hex1,
  output seg7_t hex2,
  output seg7_t hex3,
  output seg7_t hex4,
  output seg7_t hex5,
  output logic  ovf
);

`ifdef GEN_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic  tick_q;
  logic  ovf_q, ovf_d;
  seg7_t hex_q [MAX_DIGITS];
  seg7_t hex_d [MAX_DIGITS];
  bcd_t  dig   [MAX_DIGITS];
  logic [MAX_DIGITS:0] carry;
  logic  inc, all9, ovf_set;

  assign inc = gen_tick & ~tick_q & ~hold & ~clear;

  always_comb begin
    all9 = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < DIGITS && dig[i] != 4'd9) all9 = 1'b0;
  end

  // In saturate mode the increment is suppressed at max so no digit moves.
  assign carry[0] = (WRAP != 0) ? inc : (inc & ~all9);

  // Unused digit slots read as 0 and pass the carry straight through, so
  // carry[MAX_DIGITS] is always the carry out of the top active digit.
  for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_digit
    if (g < DIGITS) begin : g_used
      bcd_digit u_digit (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clear),
        .inc_in    (carry[g]),
        .q         (dig[g]),
        .carry_out (carry[g+1])
      );
    end else begin : g_unused
      assign dig[g]     = '0;
      assign carry[g+1] = carry[g];
    end
  end

  assign ovf_set = (WRAP != 0) ? carry[MAX_DIGITS] : (inc & all9);

  always_comb begin
    ovf_d = ovf_q;
    if (clear)
      ovf_d = 1'b0;
    else if (ovf_set)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tick_q <= gen_tick;
      ovf_q  <= ovf_d;
    end
  end

  // Scan from the top digit down so any_nz tells whether this digit or any
  // higher one is non-zero; digit 0 is never blanked.
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      any_nz = any_nz | (dig[i] != 4'd0);
      if (i >= DIGITS)
        hex_d[i] = SEG_BLANK;
      else if (LZ_EN && i > 0 && !any_nz)
        hex_d[i] = SEG_BLANK;
      else
        hex_d[i] = bcd_to_seg(dig[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        if (i == 0 || (!LZ_EN && i < DIGITS))
          hex_q[i] <= SEG_DIGIT[0];
        else
          hex_q[i] <= SEG_BLANK;
      end
    end else begin
      for (int i = 0; i < MAX_DIGITS; i++)
        hex_q[i] <= hex_d[i];
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_gen_count_display.sv
// Bench for gen_count_display: three instances (6 digits wrapping, 2 digits
// wrapping, 2 digits saturating) share one stimulus stream and are compared
// every cycle against an arithmetic model of the decimal count.
module tb_gen_count_display;

`ifdef GEN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam int NI = 3;
  localparam int DCFG [NI] = '{6, 2, 2};
  localparam bit WCFG [NI] = '{1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset_n, gen_tick, hold, clear;
  logic [6:0] hx [NI][6];
  logic       ov [NI];

  always #5 clk = ~clk;

  gen_count_display #(.DIGITS(6), .WRAP(1)) u_main (
    .clk(clk), .reset_n(reset_n), .gen_tick(gen_tick), .hold(hold), .clear(clear),
    .hex0(hx[0][0]), .hex1(hx[0][1]), .hex2(hx[0][2]), .hex3(hx[0][3]),
    .hex4(hx[0][4]), .hex5(hx[0][5]), .ovf(ov[0]));

  gen_count_display #(.DIGITS(2), .WRAP(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .gen_tick(gen_tick), .hold(hold), .clear(clear),
    .hex0(hx[1][0]), .hex1(hx[1][1]), .hex2(hx[1][2]), .hex3(hx[1][3]),
    .hex4(hx[1][4]), .hex5(hx[1][5]), .ovf(ov[1]));

  gen_count_display #(.DIGITS(2), .WRAP(0)) u_sat (
    .clk(clk), .reset_n(reset_n), .gen_tick(gen_tick), .hold(hold), .clear(clear),
    .hex0(hx[2][0]), .hex1(hx[2][1]), .hex2(hx[2][2]), .hex3(hx[2][3]),
    .hex4(hx[2][4]), .hex5(hx[2][5]), .ovf(ov[2]));

  // Reference model state
  int         cnt  [NI];
  bit         ovm  [NI];
  logic [6:0] exph [NI][6];
  bit         prev_tick;
  bit         chk_en;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int pow10(input int k);
    int p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return p;
  endfunction

  // Display pattern of position k for a decimal value shown on d digits.
  function automatic logic [6:0] show(input int c, input int d, input int k);
    if (k >= d) return 7'h00;
    if (LZ && k > 0 && c < pow10(k)) return 7'h00;
    return seg_tbl[(c / pow10(k)) % 10];
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("inst%0d_hex%0d", k, i), hx[k][i], exph[k][i]);
      check($sformatf("inst%0d_ovf", k), {6'b0, ov[k]}, {6'b0, ovm[k]});
    end
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then sample the DUTs 1 time unit later.
  task automatic step();
    bit edge_seen;
    @(posedge clk);
    edge_seen = gen_tick && !prev_tick && !hold;
    for (int k = 0; k < NI; k++) begin
      int maxv = pow10(DCFG[k]) - 1;
      // Hex lags the count by one cycle: it shows the pre-edge count.
      for (int i = 0; i < 6; i++)
        exph[k][i] = show(reset_n ? cnt[k] : 0, DCFG[k], i);
      if (!reset_n) begin
        cnt[k] = 0; ovm[k] = 1'b0;
      end else if (clear) begin
        cnt[k] = 0; ovm[k] = 1'b0;
      end else if (edge_seen) begin
        if (cnt[k] == maxv) begin
          ovm[k] = 1'b1;
          if (WCFG[k]) cnt[k] = 0;
        end else begin
          cnt[k] = cnt[k] + 1;
        end
      end
    end
    prev_tick = reset_n ? gen_tick : 1'b0;
    #1;
    if (chk_en) check_all();
  endtask

  task automatic pulse(input int low_cycles);
    gen_tick = 1'b1; step();
    gen_tick = 1'b0;
    for (int j = 0; j < low_cycles; j++) step();
  endtask

  task automatic do_clear();
    clear = 1'b1; step();
    clear = 1'b0; step();
  endtask

  initial begin
    reset_n = 1'b0; gen_tick = 1'b0; hold = 1'b0; clear = 1'b0;
    prev_tick = 1'b0; chk_en = 1'b1;
    for (int k = 0; k < NI; k++) begin cnt[k] = 0; ovm[k] = 1'b0; end

    // Reset for two cycles
    step(); step();
    check("rst_hex0", hx[0][0], 7'h3F);
    check("rst_hex5", hx[0][5], LZ ? 7'h00 : 7'h3F);
    reset_n = 1'b1;
    step();

    // 12 pulses, 1 high / 3 low -> 12
    for (int p = 0; p < 12; p++) pulse(3);
    check("cnt12_hex1", hx[0][1], 7'h06);
    check("cnt12_hex0", hx[0][0], 7'h5B);

    // Level held high 20 cycles counts once -> 13
    gen_tick = 1'b1;
    for (int j = 0; j < 20; j++) step();
    gen_tick = 1'b0; step(); step();
    check("held_hex0", hx[0][0], 7'h4F);

    // Ripple: 9999 then one more -> 010000
    do_clear();
    chk_en = 1'b0;
    for (int p = 0; p < 9999; p++) pulse(1);
    chk_en = 1'b1;
    step();
    check("pre_ripple_hex3", hx[0][3], 7'h6F);
    pulse(2);
    check("ripple_hex4", hx[0][4], 7'h06);
    check("ripple_hex3", hx[0][3], 7'h3F);
    check("ripple_hex0", hx[0][0], 7'h3F);
    check("ripple_hex5", hx[0][5], LZ ? 7'h00 : 7'h3F);
    check("sat_after_bulk_hex0", hx[2][0], 7'h6F);

    // Wrap / saturate on the 2-digit instances
    do_clear();
    for (int p = 0; p < 99; p++) pulse(1);
    pulse(2);
    check("wrap_hex1", hx[1][1], LZ ? 7'h00 : 7'h3F);
    check("wrap_ovf", {6'b0, ov[1]}, 7'h01);
    check("sat_hex1", hx[2][1], 7'h6F);
    check("sat_ovf", {6'b0, ov[2]}, 7'h01);
    pulse(2);
    check("sat_again_hex0", hx[2][0], 7'h6F);

    // Clear coincident with an edge
    pulse(2);
    gen_tick = 1'b1; clear = 1'b1; step();
    gen_tick = 1'b0; clear = 1'b0; step(); step();
    check("clr_edge_hex0", hx[0][0], 7'h3F);
    check("clr_edge_ovf", {6'b0, ov[2]}, 7'h00);

    // Hold drops edges; releasing hold with gen_tick high does not count
    pulse(2);
    hold = 1'b1;
    for (int p = 0; p < 5; p++) pulse(1);
    gen_tick = 1'b1; step();
    hold = 1'b0; step(); step();
    gen_tick = 1'b0; step(); step();
    check("hold_hex0", hx[0][0], 7'h06);

    // Reset mid-count at 123 with coincident edge
    do_clear();
    for (int p = 0; p < 123; p++) pulse(1);
    step();
    check("pre_rst_hex2", hx[0][2], 7'h06);
    reset_n = 1'b0; gen_tick = 1'b1; step();
    reset_n = 1'b1; gen_tick = 1'b0; step(); step();
    check("midrst_hex0", hx[0][0], 7'h3F);
    check("midrst_hex2", hx[0][2], LZ ? 7'h00 : 7'h3F);
    pulse(2);
    check("midrst_next_hex0", hx[0][0], 7'h06);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      gen_tick = 1'($urandom_range(0, 1));
      hold     = ($urandom_range(0, 7) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      reset_n  = !($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
